// File: rtl/aes_key_pkg.sv
// Shared definitions for the multi-length AES key schedule: mode encodings, per-mode lookups, FSM states.
// Latency: none, this file holds only constants, types and pure functions.
// Backpressure: not applicable.
package aes_key_pkg;

  // keyLen encodings; 2'b11 falls back to AES-128
  localparam logic [1:0] KEY_LEN_128 = 2'b00;
  localparam logic [1:0] KEY_LEN_192 = 2'b01;
  localparam logic [1:0] KEY_LEN_256 = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    EXPAND = 2'd2,
    DONE   = 2'd3
  } keyState_t;

  // Number of 32-bit key words (Nk) for a mode
  function automatic logic [3:0] nkOf(input logic [1:0] keyLen);
    case (keyLen)
      KEY_LEN_192: return 4'd6;
      KEY_LEN_256: return 4'd8;
      default:     return 4'd4;
    endcase
  endfunction

  // Number of cipher rounds (Nr = Nk + 6)
  function automatic logic [3:0] nrOf(input logic [1:0] keyLen);
    return nkOf(keyLen) + 4'd6;
  endfunction

  // Total schedule words T = 4*(Nr+1): 44, 52 or 60
  function automatic logic [5:0] totalWordsOf(input logic [1:0] keyLen);
    return {nrOf(keyLen) + 4'd1, 2'b00};
  endfunction

  // Multiply by x in GF(2^8) with the AES reduction polynomial
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/key_expand_word.sv
// Combinational next-word datapath of the AES key schedule: w[i] from w[i-1], w[i-Nk] and the S-box result.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller owns sequencing and S-box sharing.
module key_expand_word (
  input  logic [31:0] prevWord,
  input  logic [31:0] backWord,
  input  logic [2:0]  phase,
  input  logic [3:0]  nk,
  input  logic [7:0]  rcon,
  input  logic [31:0] sBoxResponse,
  output logic [31:0] nextWord
);

  logic [31:0] tmp;

  // Select the transform for this schedule position; the S-box sees the unrotated word,
  // so RotWord is applied to its result (the two commute).
  always_comb begin
    tmp = prevWord;
    if (phase == 3'd0) begin
      tmp = {sBoxResponse[23:0], sBoxResponse[31:24]} ^ {rcon, 24'h000000};
    end else if ((nk == 4'd8) && (phase == 3'd4)) begin
      tmp = sBoxResponse;
    end
    nextWord = backWord ^ tmp;
  end

endmodule

// File: rtl/key_expand_multi.sv
// AES-128/192/256 key expansion, one schedule word per cycle, round keys served by index. Option: KEYGEN_ZEROIZE_EN.
// Latency: ready rises T-Nk+2 cycles after init (42 / 48 / 54); roundKey read is combinational.
// Backpressure: none; init outside IDLE is ignored, S-box response is expected in the same cycle.
module key_expand_multi
  import aes_key_pkg::*;
#(
  parameter int MAX_WORDS = 60,
  parameter int ROUND_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
`ifdef KEYGEN_ZEROIZE_EN
  input  logic               zeroize,
`endif
  input  logic               init,
  input  logic [1:0]         keyLen,
  input  logic [255:0]       key,
  input  logic [ROUND_W-1:0] round,
  output logic [127:0]       roundKey,
  output logic               ready,
  output logic [3:0]         numRounds,
  output logic [31:0]        sBoxRequest,
  input  logic [31:0]        sBoxResponse
);

  localparam int IDX_W = $clog2(MAX_WORDS);

  logic [31:0]      w [MAX_WORDS];
  keyState_t        state;
  logic [1:0]       mode;
  logic [IDX_W-1:0] wordIdx;
  logic [2:0]       phase;
  logic [7:0]       rcon;

  logic [3:0]       nk;
  logic [IDX_W-1:0] lastIdx;
  logic [IDX_W-1:0] prevIdx;
  logic [IDX_W-1:0] backIdx;
  logic [31:0]      nextWord;
  logic             clearAll;

`ifdef KEYGEN_ZEROIZE_EN
  assign clearAll = zeroize;
`else
  assign clearAll = 1'b0;
`endif

  assign nk      = nkOf(mode);
  assign lastIdx = IDX_W'(totalWordsOf(mode) - 6'd1);

  // Guard the look-back indices so idle states never address outside the store
  assign prevIdx = (wordIdx == '0) ? '0 : wordIdx - IDX_W'(1);
  assign backIdx = (wordIdx >= IDX_W'(nk)) ? wordIdx - IDX_W'(nk) : '0;

  assign sBoxRequest = w[prevIdx];

  key_expand_word uWord (
    .prevWord    (w[prevIdx]),
    .backWord    (w[backIdx]),
    .phase       (phase),
    .nk          (nk),
    .rcon        (rcon),
    .sBoxResponse(sBoxResponse),
    .nextWord    (nextWord)
  );

  // Round-key read: four consecutive words, forced to zero beyond the latched Nr
  always_comb begin
    int base;
    base     = 4 * int'(round);
    roundKey = '0;
    if ((int'(round) <= int'(numRounds)) && (base + 3 < MAX_WORDS)) begin
      roundKey = {w[IDX_W'(base)], w[IDX_W'(base + 1)],
                  w[IDX_W'(base + 2)], w[IDX_W'(base + 3)]};
    end
  end

  // Schedule FSM: latch mode, load the key words, expand one word per cycle, flag completion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < MAX_WORDS; k++) begin
        w[IDX_W'(k)] <= '0;
      end
      state     <= IDLE;
      mode      <= KEY_LEN_128;
      wordIdx   <= '0;
      phase     <= '0;
      rcon      <= '0;
      ready     <= 1'b0;
      numRounds <= 4'd10;
    end else if (clearAll) begin
      for (int k = 0; k < MAX_WORDS; k++) begin
        w[IDX_W'(k)] <= '0;
      end
      state   <= IDLE;
      wordIdx <= '0;
      phase   <= '0;
      rcon    <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (init) begin
            mode      <= keyLen;
            numRounds <= nrOf(keyLen);
            ready     <= 1'b0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          // Key is MSB-aligned: word k comes from the k-th 32-bit slice from the top
          for (int k = 0; k < 8; k++) begin
            if (k < int'(nk)) begin
              w[IDX_W'(k)] <= key[255 - 32*k -: 32];
            end
          end
          wordIdx <= IDX_W'(nk);
          phase   <= '0;
          rcon    <= 8'h01;
          state   <= EXPAND;
        end
        EXPAND: begin
          w[wordIdx] <= nextWord;
          if (phase == 3'd0) begin
            rcon <= xtime(rcon);
          end
          phase   <= (phase == 3'(nk - 4'd1)) ? 3'd0 : phase + 3'd1;
          wordIdx <= wordIdx + IDX_W'(1);
          if (wordIdx == lastIdx) begin
            state <= DONE;
          end
        end
        DONE: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_expand_multi.sv
// Directed bench for key_expand_multi using FIPS-197 key-expansion vectors and a local S-box table.
// Latency: checks ready timing of 42/48/54 cycles after init for the three modes.
// Backpressure: not applicable; S-box answers combinationally.
module tb_key_expand_multi;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         clk = 1'b0;
  logic         reset;
  logic         init;
  logic [1:0]   keyLen;
  logic [255:0] key;
  logic [3:0]   round;
  logic [127:0] roundKey;
  logic         ready;
  logic [3:0]   numRounds;
  logic [31:0]  sBoxRequest;
  logic [31:0]  sBoxResponse;
`ifdef KEYGEN_ZEROIZE_EN
  logic         zeroize;
`endif

  int total = 0;
  int bad   = 0;
  int cyc;
  logic readyAfter;

  always #5 clk = ~clk;

  key_expand_multi dut (
    .clk         (clk),
    .reset       (reset),
`ifdef KEYGEN_ZEROIZE_EN
    .zeroize     (zeroize),
`endif
    .init        (init),
    .keyLen      (keyLen),
    .key         (key),
    .round       (round),
    .roundKey    (roundKey),
    .ready       (ready),
    .numRounds   (numRounds),
    .sBoxRequest (sBoxRequest),
    .sBoxResponse(sBoxResponse)
  );

  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  always_comb begin
    sBoxResponse = {sb(sBoxRequest[31:24]), sb(sBoxRequest[23:16]),
                    sb(sBoxRequest[15:8]),  sb(sBoxRequest[7:0])};
  end

  task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic readKey(input logic [3:0] r, input string tag, input logic [127:0] want);
    round = r;
    #1;
    checkVal(tag, roundKey, want);
  endtask

  // Pulse init, optionally pulse a stray init at cycle pulseAt, and count cycles until ready
  task automatic runKey(input logic [1:0] len, input logic [255:0] k, input int pulseAt,
                        output int cycles, output logic readyAfterInit);
    @(posedge clk); #1;
    keyLen = len;
    key    = k;
    init   = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    readyAfterInit = ready;
    cycles = 0;
    while (ready !== 1'b1 && cycles < 200) begin
      @(posedge clk);
      cycles++;
      #1;
      if (cycles == pulseAt) begin
        init   = 1'b1;
        keyLen = 2'b10;
        key    = '1;
      end else begin
        init = 1'b0;
      end
    end
    init = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b0;
    init   = 1'b0;
    keyLen = 2'b00;
    key    = '0;
    round  = '0;
`ifdef KEYGEN_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    #12;
    checkVal("rst_ready", 128'(ready), 128'd0);
    checkVal("rst_nr", 128'(numRounds), 128'd10);
    readKey(4'd0, "rst_rk0", 128'h0);
    @(negedge clk);
    reset = 1'b1;

    // AES-128
    runKey(2'b00, KEY128, -1, cyc, readyAfter);
    checkVal("lat128", 128'(cyc), 128'd42);
    checkVal("nr128", 128'(numRounds), 128'd10);
    readKey(4'd0,  "r0_128",  128'h2b7e151628aed2a6abf7158809cf4f3c);
    readKey(4'd1,  "r1_128",  128'ha0fafe1788542cb123a339392a6c7605);
    readKey(4'd10, "r10_128", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    readKey(4'd11, "r11_128", 128'h0);
    readKey(4'd15, "r15_128", 128'h0);

    // AES-192
    runKey(2'b01, KEY192, -1, cyc, readyAfter);
    checkVal("drop192", 128'(readyAfter), 128'd0);
    checkVal("lat192", 128'(cyc), 128'd48);
    checkVal("nr192", 128'(numRounds), 128'd12);
    readKey(4'd0,  "r0_192",  128'h8e73b0f7da0e6452c810f32b809079e5);
    readKey(4'd1,  "r1_192",  128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    readKey(4'd12, "r12_192", 128'he98ba06f448c773c8ecc720401002202);
    readKey(4'd13, "r13_192", 128'h0);

    // AES-256
    runKey(2'b10, KEY256, -1, cyc, readyAfter);
    checkVal("drop256", 128'(readyAfter), 128'd0);
    checkVal("lat256", 128'(cyc), 128'd54);
    checkVal("nr256", 128'(numRounds), 128'd14);
    readKey(4'd0,  "r0_256",  128'h603deb1015ca71be2b73aef0857d7781);
    readKey(4'd1,  "r1_256",  128'h1f352c073b6108d72d9810a30914dff4);
    readKey(4'd2,  "r2_256",  128'h9ba354118e6925afa51a8b5f2067fcde);
    readKey(4'd3,  "r3_256",  128'ha8b09c1a93d194cdbe49846eb75d5b9a);
    readKey(4'd14, "r14_256", 128'hfe4890d1e6188d0b046df344706c631e);
    readKey(4'd15, "r15_256", 128'h0);

    // AES-128 with a stray init during EXPAND
    runKey(2'b00, KEY128, 10, cyc, readyAfter);
    checkVal("lat_pulse", 128'(cyc), 128'd42);
    checkVal("nr_pulse", 128'(numRounds), 128'd10);
    readKey(4'd1,  "r1_pulse",  128'ha0fafe1788542cb123a339392a6c7605);
    readKey(4'd10, "r10_pulse", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // keyLen 2'b11 behaves as AES-128
    runKey(2'b11, KEY128, -1, cyc, readyAfter);
    checkVal("lat_k11", 128'(cyc), 128'd42);
    checkVal("nr_k11", 128'(numRounds), 128'd10);
    readKey(4'd10, "r10_k11", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reset in the middle of an AES-256 expansion
    @(posedge clk); #1;
    keyLen = 2'b10;
    key    = KEY256;
    init   = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkVal("midrst_ready", 128'(ready), 128'd0);
    checkVal("midrst_nr", 128'(numRounds), 128'd10);
    for (int r = 0; r < 16; r++) begin
      readKey(4'(r), $sformatf("midrst_rk%0d", r), 128'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    runKey(2'b10, KEY256, -1, cyc, readyAfter);
    checkVal("lat_after_rst", 128'(cyc), 128'd54);
    readKey(4'd3,  "r3_after_rst",  128'ha8b09c1a93d194cdbe49846eb75d5b9a);
    readKey(4'd14, "r14_after_rst", 128'hfe4890d1e6188d0b046df344706c631e);

`ifdef KEYGEN_ZEROIZE_EN
    // Zeroize wins over a simultaneous init
    runKey(2'b00, KEY128, -1, cyc, readyAfter);
    checkVal("zz_pre_ready", 128'(ready), 128'd1);
    @(posedge clk); #1;
    zeroize = 1'b1;
    init    = 1'b1;
    keyLen  = 2'b00;
    key     = KEY128;
    @(posedge clk); #1;
    zeroize = 1'b0;
    init    = 1'b0;
    checkVal("zz_ready", 128'(ready), 128'd0);
    readKey(4'd0, "zz_rk0", 128'h0);
    repeat (3) @(posedge clk);
    #1;
    checkVal("zz_idle_ready", 128'(ready), 128'd0);
    readKey(4'd0, "zz_idle_rk0", 128'h0);
    readKey(4'd10, "zz_idle_rk10", 128'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
